reg_pipe: RTL and testbench
===========================

REG_PIPE -- requirements
Module: reg_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (>=1).
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1).
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit data value loaded into every stage on reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 en  input  1  advance enable; 0 = stall, all stages hold.
REQ-007 flush  input  1  clear all stage valid bits.
REQ-008 d  input  WIDTH  data into stage 0.
REQ-009 d_valid  input  1  qualifies d.
REQ-010 q  output  WIDTH  data of stage DEPTH-1.
REQ-011 q_valid  output  1  valid bit of stage DEPTH-1.
REQ-012 count  output  $clog2(DEPTH+1)  number of stages currently holding valid data.

Function
REQ-013 State: DEPTH stages, each one WIDTH-bit data register plus one valid bit; q, q_valid, count driven directly from registers, no combinational path from inputs.
REQ-014 Priority per rising edge: rst > flush > en > hold.
REQ-015 en=1, flush=0: stage0 <= {d, d_valid}; stage i <= stage i-1 for i=1..DEPTH-1; previous stage DEPTH-1 content discarded.
REQ-016 en=0, flush=0: all data and valid bits hold; d, d_valid ignored.
REQ-017 flush=1 (regardless of en): all valid bits <= 0; data registers hold; d not captured; count <= 0 on same edge.
REQ-018 Latency: a word presented with en=1 appears on q/q_valid after exactly DEPTH enabled edges; stalled cycles add no loss and no duplication.
REQ-019 Invalid words (d_valid=0) still shift data but carry valid=0; bubbles preserved in order.
REQ-020 count equals population count of valid bits after each edge; range 0..DEPTH, saturation impossible by construction; width sufficient for DEPTH.
REQ-021 DEPTH=1: single stage, latency 1, count is 1 bit.

Reset
REQ-022 rst=1 at rising edge: every data register <= RESET_VAL, every valid bit <= 0, count <= 0; q=RESET_VAL, q_valid=0 from that edge.
REQ-023 Reset mid-operation discards all in-flight words; en, flush, d ignored while rst=1.
REQ-024 Before first reset, output values are unspecified; bench checks only after first reset edge.

Configuration
REQ-025 Macro REG_PIPE_PARITY_EN, when defined: each stage stores an extra even-parity bit of its data, shifted with data under REQ-015..017/022 rules (reset parity = parity of RESET_VAL).
REQ-026 With REG_PIPE_PARITY_EN: extra input perr_inj (1 bit) inverts parity bit captured into stage 0 when en=1; extra output perr (1 bit) = q_valid AND (stored parity != ^q), registered-path only.
REQ-027 Without REG_PIPE_PARITY_EN: no parity storage, no perr_inj or perr ports; behaviour otherwise identical.

Verification
REQ-028 WIDTH=8, DEPTH=4, RESET_VAL=8'hA5: assert rst one cycle -> q=8'hA5, q_valid=0, count=0.
REQ-029 en=1, d_valid=1, d=8'h01,02,03,04 on consecutive edges -> q=8'h01 with q_valid=1 on 4th edge, count=4; then 02,03,04 on following edges.
REQ-030 Load 8'h11,22 then en=0 for 5 cycles -> q, q_valid, count (=2) unchanged during stall; resume en=1 -> 8'h11 emerges 2 edges later.
REQ-031 Pattern valid,invalid,valid (8'h10,xx,8'h30) -> q_valid sequence 1,0,1 at DEPTH-latency; count peaks at 2; flush with count=3 -> count=0, q_valid=0 next edge, q data unchanged.
REQ-032 rst asserted together with flush and en while count=3 -> all stages RESET_VAL, count=0.
REQ-033 REG_PIPE_PARITY_EN defined: d=8'h07 with perr_inj=1 -> perr=1 exactly when that word at q (DEPTH edges later); neighbouring words perr=0; macro undefined build compiles without perr ports.

Source files
------------

// File: rtl/reg_pipe_if.sv
// reg_pipe_if: data/handshake bundle for reg_pipe.
// master = producer/consumer side (testbench), slave = pipeline side.
// The perr_inj/perr signals exist only when REG_PIPE_PARITY_EN is defined.
interface reg_pipe_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                           en;
    logic                           flush;
    logic [WIDTH-1:0]               d;
    logic                           d_valid;
    logic [WIDTH-1:0]               q;
    logic                           q_valid;
    logic [$clog2(DEPTH+1)-1:0]     count;
`ifdef REG_PIPE_PARITY_EN
    logic                           perr_inj;
    logic                           perr;
`endif

    modport master (
        output en, flush, d, d_valid,
`ifdef REG_PIPE_PARITY_EN
        output perr_inj,
        input  perr,
`endif
        input  q, q_valid, count
    );

    modport slave (
        input  en, flush, d, d_valid,
`ifdef REG_PIPE_PARITY_EN
        input  perr_inj,
        output perr,
`endif
        output q, q_valid, count
    );
endinterface

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage register pipeline with per-stage valid bits,
// stall (en=0), flush (clears valids, keeps data) and a live valid count.
// Optional feature macro REG_PIPE_PARITY_EN adds a per-stage even-parity
// bit, a parity-error inject input (perr_inj) and an error output (perr).
module reg_pipe #(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    reg_pipe_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [CW-1:0]               count_q, count_d;
`ifdef REG_PIPE_PARITY_EN
    logic [DEPTH-1:0]            par_q, par_d;
`endif

    // Next-state: flush clears valids only; enable shifts one stage;
    // otherwise everything holds. Count tracks the valid popcount
    // incrementally (new word in, oldest word out).
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;
`ifdef REG_PIPE_PARITY_EN
        par_d   = par_q;
`endif
        if (bus.flush) begin
            valid_d = '0;
            count_d = '0;
        end else if (bus.en) begin
            for (int unsigned i = DEPTH - 1; i >= 1; i--) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
`ifdef REG_PIPE_PARITY_EN
                par_d[i]   = par_q[i-1];
`endif
            end
            data_d[0]  = bus.d;
            valid_d[0] = bus.d_valid;
`ifdef REG_PIPE_PARITY_EN
            par_d[0]   = (^bus.d) ^ bus.perr_inj;
`endif
            count_d = count_q + CW'(bus.d_valid) - CW'(valid_q[DEPTH-1]);
        end
    end

    // Stage registers with synchronous reset to RESET_VAL / empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
            valid_q <= '0;
            count_q <= '0;
`ifdef REG_PIPE_PARITY_EN
            par_q   <= {DEPTH{^RESET_VAL}};
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
`ifdef REG_PIPE_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.q       = data_q[DEPTH-1];
    assign bus.q_valid = valid_q[DEPTH-1];
    assign bus.count   = count_q;
`ifdef REG_PIPE_PARITY_EN
    assign bus.perr    = valid_q[DEPTH-1] & (par_q[DEPTH-1] != (^data_q[DEPTH-1]));
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed-vector bench for reg_pipe (WIDTH=8, DEPTH=4,
// RESET_VAL=8'hA5). Parity checks run only when REG_PIPE_PARITY_EN is defined.
module tb_reg_pipe;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    reg_pipe_if #(.WIDTH(8), .DEPTH(4)) bus ();

    reg_pipe #(
        .WIDTH     (8),
        .DEPTH     (4),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic flush, input logic [7:0] d, input logic dv);
        bus.en      = en;
        bus.flush   = flush;
        bus.d       = d;
        bus.d_valid = dv;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
`ifdef REG_PIPE_PARITY_EN
        bus.perr_inj = 1'b0;
`endif
        // Reset state
        do_reset();
        check("rst_q", bus.q, 8'hA5);
        check("rst_qv", bus.q_valid, 0);
        check("rst_cnt", bus.count, 0);

        // Fill with 01..04, latency of DEPTH edges
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 1'b0, 8'(k), 1'b1);
            step();
            check("fill_cnt", bus.count, k);
            check("fill_qv", bus.q_valid, (k == 4) ? 1 : 0);
        end
        check("fill_q", bus.q, 8'h01);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        step(); check("drain_q2", bus.q, 8'h02); check("drain_cnt3", bus.count, 3);
        step(); check("drain_q3", bus.q, 8'h03); check("drain_cnt2", bus.count, 2);
        step(); check("drain_q4", bus.q, 8'h04); check("drain_cnt1", bus.count, 1);
        step(); check("drain_qv", bus.q_valid, 0); check("drain_cnt0", bus.count, 0);
        check("drain_bub", bus.q, 8'h00);

        // Stall: d/d_valid ignored, nothing moves
        do_reset();
        drive(1'b1, 1'b0, 8'h11, 1'b1); step();
        drive(1'b1, 1'b0, 8'h22, 1'b1); step();
        check("load_cnt", bus.count, 2);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 8'hFF, 1'b1);
            step();
            check("stall_cnt", bus.count, 2);
            check("stall_q", bus.q, 8'hA5);
            check("stall_qv", bus.q_valid, 0);
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        step(); check("resume1_qv", bus.q_valid, 0); check("resume1_cnt", bus.count, 2);
        step(); check("resume2_q", bus.q, 8'h11); check("resume2_qv", bus.q_valid, 1);
        step(); check("resume3_q", bus.q, 8'h22); check("resume3_cnt", bus.count, 1);

        // Bubble ordering: valid, invalid, valid
        do_reset();
        drive(1'b1, 1'b0, 8'h10, 1'b1); step(); check("bub_c1", bus.count, 1);
        drive(1'b1, 1'b0, 8'hEE, 1'b0); step(); check("bub_c2", bus.count, 1);
        drive(1'b1, 1'b0, 8'h30, 1'b1); step(); check("bub_c3", bus.count, 2);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        step(); check("bub_qv4", bus.q_valid, 1); check("bub_q4", bus.q, 8'h10); check("bub_c4", bus.count, 2);
        step(); check("bub_qv5", bus.q_valid, 0); check("bub_q5", bus.q, 8'hEE); check("bub_c5", bus.count, 1);
        step(); check("bub_qv6", bus.q_valid, 1); check("bub_q6", bus.q, 8'h30); check("bub_c6", bus.count, 1);
        step(); check("bub_c7", bus.count, 0);

        // Flush with count=3: valids clear, data holds, d not captured
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 8'h41 + 8'(k), 1'b1);
            step();
        end
        drive(1'b1, 1'b0, 8'h00, 1'b0); step();
        check("pre_fl_cnt", bus.count, 3);
        check("pre_fl_q", bus.q, 8'h42);
        drive(1'b1, 1'b1, 8'h99, 1'b1); step();
        check("fl_cnt", bus.count, 0);
        check("fl_qv", bus.q_valid, 0);
        check("fl_q", bus.q, 8'h42);
        drive(1'b1, 1'b0, 8'h00, 1'b0); step();
        check("post_fl_q", bus.q, 8'h43);
        check("post_fl_qv", bus.q_valid, 0);
        check("post_fl_cnt", bus.count, 0);

        // Reset beats flush and en mid-operation
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 8'h51 + 8'(k), 1'b1);
            step();
        end
        check("pre_rst_cnt", bus.count, 3);
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h77, 1'b1);
        step();
        rst = 1'b0;
        check("mid_rst_cnt", bus.count, 0);
        check("mid_rst_q", bus.q, 8'hA5);
        check("mid_rst_qv", bus.q_valid, 0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("mid_rst_stage", bus.q, 8'hA5);
        end

`ifdef REG_PIPE_PARITY_EN
        // Parity inject on the middle word only
        do_reset();
        check("rst_perr", bus.perr, 0);
        drive(1'b1, 1'b0, 8'h06, 1'b1); bus.perr_inj = 1'b0; step();
        drive(1'b1, 1'b0, 8'h07, 1'b1); bus.perr_inj = 1'b1; step();
        drive(1'b1, 1'b0, 8'h08, 1'b1); bus.perr_inj = 1'b0; step();
        drive(1'b1, 1'b0, 8'h00, 1'b0); step();
        check("par_q06", bus.q, 8'h06); check("perr_06", bus.perr, 0);
        step(); check("par_q07", bus.q, 8'h07); check("perr_07", bus.perr, 1);
        step(); check("par_q08", bus.q, 8'h08); check("perr_08", bus.perr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
